// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, RMW op
// encodings, mstatus/mie/mip bit positions and mcause codes.
// Used by csr_unit and csr_cycle_counter.
package csr_unit_pkg;

  // CSR addresses
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  // Read-modify-write operation carried with a committing CSR instruction
  typedef enum logic [1:0] {
    CSR_OP_RW   = 2'd0,
    CSR_OP_RS   = 2'd1,
    CSR_OP_RC   = 2'd2,
    CSR_OP_NONE = 2'd3
  } csr_op_e;

  // Bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  // mcause exception / interrupt codes
  localparam int MCAUSE_ECALL_M = 11;
  localparam int MCAUSE_MTI     = 7;

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter; a write replaces the whole value for
// that cycle (the caller merges the untouched half). Only built when
// CSR_CYCLE_COUNTER_EN is defined.
module csr_cycle_counter (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [63:0] wr_val,
  output logic [63:0] count
);

  // Count every cycle; a CSR write overrides the increment
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      count <= 64'd0;
    end else if (wr_en) begin
      count <= wr_val;
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with ecall/mret/timer-interrupt sequencing and
// fetch redirect. Combinational read port (no write bypass), writes land at
// the next edge. Optional mcycle/mcycleh counter under CSR_CYCLE_COUNTER_EN.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic [11:0]     D_csr_read_addr_i,
  output logic [XLEN-1:0] D_csr_data_o,
  output logic            D_csr_illegal_o,
  input  logic            MD_need_CSR_i,
  input  logic [1:0]      MD_csr_op_i,
  input  logic [11:0]     MD_csr_addr_i,
  input  logic [XLEN-1:0] MD_csr_src_i,
  input  logic            MD_ecall_i,
  input  logic            MD_mret_i,
  input  logic            MD_commit_valid_i,
  input  logic [XLEN-1:0] MD_pc_i,
  input  logic            timer_irq_i,
  output logic            trap_redirect_o,
  output logic [XLEN-1:0] trap_target_o
);

  logic            st_mie, st_mpie, mtie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
  logic [XLEN:0]   rd_port, wr_port;
  logic [XLEN-1:0] wr_old, wval;
  logic            writable, irq_take, trap_take, mret_take, wr_en;
  csr_op_e         op;

`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0] cyc;
  logic        cyc_wr;
  logic [63:0] cyc_wval;
`endif

  assign op = csr_op_e'(MD_csr_op_i);

  // Assemble architectural views of the sparse status registers
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MIE_BIT]  = st_mie;
    mstatus_rd[MSTATUS_MPIE_BIT] = st_mpie;
    mie_rd = '0;
    mie_rd[MIE_MTIE_BIT] = mtie;
    mip_rd = '0;
    mip_rd[MIP_MTIP_BIT] = timer_irq_i;
  end

  // Returns {illegal, value} for an address; shared by read and RMW paths
  function automatic logic [XLEN:0] csr_read(input logic [11:0] addr);
    logic [XLEN:0] r;
    r = '0;
    case (addr)
      ADDR_MSTATUS:  r[XLEN-1:0] = mstatus_rd;
      ADDR_MIE:      r[XLEN-1:0] = mie_rd;
      ADDR_MTVEC:    r[XLEN-1:0] = mtvec;
      ADDR_MSCRATCH: r[XLEN-1:0] = mscratch;
      ADDR_MEPC:     r[XLEN-1:0] = mepc;
      ADDR_MCAUSE:   r[XLEN-1:0] = mcause;
      ADDR_MIP:      r[XLEN-1:0] = mip_rd;
      ADDR_MHARTID:  r[XLEN-1:0] = HART_ID;
`ifdef CSR_CYCLE_COUNTER_EN
      ADDR_MCYCLE:   r[XLEN-1:0] = cyc[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) r[XLEN-1:0] = XLEN'(cyc[63:32]);
        else            r[XLEN] = 1'b1;
      end
`else
      ADDR_MCYCLE, ADDR_MCYCLEH: r = '0;
`endif
      default:       r[XLEN] = 1'b1;
    endcase
    return r;
  endfunction

  assign rd_port         = csr_read(D_csr_read_addr_i);
  assign D_csr_data_o    = rd_port[XLEN-1:0];
  assign D_csr_illegal_o = rd_port[XLEN];
  assign wr_port         = csr_read(MD_csr_addr_i);
  assign wr_old          = wr_port[XLEN-1:0];

  // Decide which single event acts this cycle and the RMW write value
  always_comb begin
    writable = ~wr_port[XLEN] & (MD_csr_addr_i != ADDR_MIP) & (MD_csr_addr_i != ADDR_MHARTID);
`ifndef CSR_CYCLE_COUNTER_EN
    if (MD_csr_addr_i == ADDR_MCYCLE || MD_csr_addr_i == ADDR_MCYCLEH) writable = 1'b0;
`endif
    irq_take  = ~rst & MD_commit_valid_i & st_mie & mtie & timer_irq_i;
    trap_take = irq_take | (~rst & MD_ecall_i);
    mret_take = ~rst & MD_mret_i & ~MD_ecall_i & ~irq_take;
    wr_en     = ~rst & MD_need_CSR_i & (op != CSR_OP_NONE) & writable & ~trap_take & ~mret_take;
    case (op)
      CSR_OP_RW: wval = MD_csr_src_i;
      CSR_OP_RS: wval = wr_old | MD_csr_src_i;
      CSR_OP_RC: wval = wr_old & ~MD_csr_src_i;
      default:   wval = wr_old;
    endcase
  end

  assign trap_redirect_o = trap_take | mret_take;
  assign trap_target_o   = trap_take ? mtvec : (mret_take ? mepc : '0);

  // Trap entry/return sequencing and CSR writes, highest priority first
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mtie     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= XLEN'(MCAUSE_ECALL_M);
    end else if (trap_take) begin
      mepc    <= MD_pc_i & ~XLEN'(3);
      mcause  <= irq_take ? {1'b1, (XLEN-1)'(MCAUSE_MTI)} : XLEN'(MCAUSE_ECALL_M);
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_take) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr_en) begin
      case (MD_csr_addr_i)
        ADDR_MSTATUS: begin
          st_mie  <= wval[MSTATUS_MIE_BIT];
          st_mpie <= wval[MSTATUS_MPIE_BIT];
        end
        ADDR_MIE:      mtie     <= wval[MIE_MTIE_BIT];
        ADDR_MTVEC:    mtvec    <= wval & ~XLEN'(3);
        ADDR_MSCRATCH: mscratch <= wval;
        ADDR_MEPC:     mepc     <= wval & ~XLEN'(3);
        ADDR_MCAUSE:   mcause   <= wval;
        default: ;
      endcase
    end
  end

`ifdef CSR_CYCLE_COUNTER_EN
  // Merge a half-word write into the full counter value
  always_comb begin
    cyc_wr   = wr_en & ((MD_csr_addr_i == ADDR_MCYCLE) | (MD_csr_addr_i == ADDR_MCYCLEH));
    cyc_wval = cyc;
    if (XLEN == 64)                           cyc_wval        = 64'(wval);
    else if (MD_csr_addr_i == ADDR_MCYCLEH)   cyc_wval[63:32] = wval[31:0];
    else                                      cyc_wval[31:0]  = wval[31:0];
  end

  csr_cycle_counter u_cycle (
    .clk_i  (clk_i),
    .rst    (rst),
    .wr_en  (cyc_wr),
    .wr_val (cyc_wval),
    .count  (cyc)
  );
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit (XLEN=32): stimulus pushes expected
// {illegal,data} and {redirect,target}; a negedge monitor pops and compares.
// Counter expectations follow CSR_CYCLE_COUNTER_EN.
module tb_csr_unit;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [11:0] D_csr_read_addr_i;
  logic [31:0] D_csr_data_o;
  logic        D_csr_illegal_o;
  logic        MD_need_CSR_i;
  logic [1:0]  MD_csr_op_i;
  logic [11:0] MD_csr_addr_i;
  logic [31:0] MD_csr_src_i;
  logic        MD_ecall_i;
  logic        MD_mret_i;
  logic        MD_commit_valid_i;
  logic [31:0] MD_pc_i;
  logic        timer_irq_i;
  logic        trap_redirect_o;
  logic [31:0] trap_target_o;

  csr_unit dut (
    .clk_i             (clk_i),
    .rst               (rst),
    .D_csr_read_addr_i (D_csr_read_addr_i),
    .D_csr_data_o      (D_csr_data_o),
    .D_csr_illegal_o   (D_csr_illegal_o),
    .MD_need_CSR_i     (MD_need_CSR_i),
    .MD_csr_op_i       (MD_csr_op_i),
    .MD_csr_addr_i     (MD_csr_addr_i),
    .MD_csr_src_i      (MD_csr_src_i),
    .MD_ecall_i        (MD_ecall_i),
    .MD_mret_i         (MD_mret_i),
    .MD_commit_valid_i (MD_commit_valid_i),
    .MD_pc_i           (MD_pc_i),
    .timer_irq_i       (timer_irq_i),
    .trap_redirect_o   (trap_redirect_o),
    .trap_target_o     (trap_target_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
                          A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342,
                          A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80,
                          A_MHARTID = 12'hF14;

`ifdef CSR_CYCLE_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic [31:0] exp_d_q[$];
  logic        exp_i_q[$];
  logic        exp_r_q[$];
  logic [31:0] exp_t_q[$];
  string       exp_n_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        smp_vld = 1'b0;

  // Monitor: compare on every sampled cycle, flag redirects nobody expected
  always @(negedge clk_i) begin
    if (smp_vld) begin
      if (exp_d_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: sample requested with empty scoreboard");
      end else begin
        logic [31:0] ed, et;
        logic ei, er;
        string nm;
        ed = exp_d_q.pop_front(); ei = exp_i_q.pop_front();
        er = exp_r_q.pop_front(); et = exp_t_q.pop_front(); nm = exp_n_q.pop_front();
        checks++;
        if ({D_csr_illegal_o, D_csr_data_o} !== {ei, ed}) begin
          failures++;
          $display("FAIL %s read: got ill=%b data=%h, want ill=%b data=%h",
                   nm, D_csr_illegal_o, D_csr_data_o, ei, ed);
        end
        checks++;
        if ({trap_redirect_o, trap_target_o} !== {er, et}) begin
          failures++;
          $display("FAIL %s redirect: got %b/%h, want %b/%h",
                   nm, trap_redirect_o, trap_target_o, er, et);
        end
      end
    end else if (trap_redirect_o !== 1'b0) begin
      checks++; failures++;
      $display("FAIL spurious_redirect: got redirect=%b target=%h, want 0", trap_redirect_o, trap_target_o);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    smp_vld = 1'b0;
  endtask

  task automatic expect_out(input logic [11:0] a, input logic [31:0] d, input logic ill,
                            input logic rd, input logic [31:0] tg, input string nm);
    D_csr_read_addr_i = a;
    exp_d_q.push_back(d); exp_i_q.push_back(ill);
    exp_r_q.push_back(rd); exp_t_q.push_back(tg); exp_n_q.push_back(nm);
    smp_vld = 1'b1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic ill, input string nm);
    expect_out(a, d, ill, 1'b0, 32'h0, nm);
    tick();
  endtask

  task automatic clear_md();
    MD_need_CSR_i = 0; MD_csr_op_i = 0; MD_csr_addr_i = 0; MD_csr_src_i = 0;
    MD_ecall_i = 0; MD_mret_i = 0; MD_commit_valid_i = 0; MD_pc_i = 0;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
    MD_need_CSR_i = 1; MD_csr_op_i = op; MD_csr_addr_i = a; MD_csr_src_i = src;
    MD_commit_valid_i = 1;
    tick();
    clear_md();
  endtask

  initial begin
    rst = 1'b1; D_csr_read_addr_i = 12'h0; timer_irq_i = 1'b0;
    clear_md();
    tick();

    // Reset state
    rd(A_MSTATUS, 32'h1800, 0, "rst_mstatus");
    rd(A_MCAUSE,  32'hB,    0, "rst_mcause");
    rd(A_MTVEC,   32'h0,    0, "rst_mtvec");
    rd(A_MCYCLE,  32'h0,    0, "rst_mcycle");
    rst = 1'b0;
    repeat (5) tick();
    rd(A_MCYCLE, CNT_ON ? 32'd5 : 32'd0, 0, "mcycle_after5");
    rd(A_MHARTID, 32'h0, 0, "mhartid");
    rd(12'h7C0,   32'h0, 1, "illegal_7c0");

    // RMW ops
    csr_wr(2'd0, A_MTVEC, 32'h80000103);
    rd(A_MTVEC, 32'h80000100, 0, "mtvec_rw");
    csr_wr(2'd0, A_MSCRATCH, 32'h0F);
    csr_wr(2'd1, A_MSCRATCH, 32'hF0);
    rd(A_MSCRATCH, 32'hFF, 0, "mscratch_rs");
    csr_wr(2'd2, A_MSCRATCH, 32'h03);
    rd(A_MSCRATCH, 32'hFC, 0, "mscratch_rc");
    csr_wr(2'd3, A_MSCRATCH, 32'h01);
    rd(A_MSCRATCH, 32'hFC, 0, "op_reserved");
    csr_wr(2'd0, A_MHARTID, 32'h55);
    rd(A_MHARTID, 32'h0, 0, "mhartid_ro");
    csr_wr(2'd0, A_MIP, 32'hFF);
    rd(A_MIP, 32'h0, 0, "mip_ro");
    csr_wr(2'd0, A_MEPC, 32'h1237);
    rd(A_MEPC, 32'h1234, 0, "mepc_align");
    csr_wr(2'd0, A_MIE, 32'hFFFFFFFF);
    rd(A_MIE, 32'h80, 0, "mie_mask");
    csr_wr(2'd1, A_MSTATUS, 32'h8);
    rd(A_MSTATUS, 32'h1808, 0, "mstatus_mie");

    // ecall then mret
    MD_ecall_i = 1; MD_pc_i = 32'h1000; MD_commit_valid_i = 1;
    expect_out(A_MEPC, 32'h1234, 0, 1, 32'h80000100, "ecall");
    tick(); clear_md();
    rd(A_MEPC,    32'h1000, 0, "ecall_mepc");
    rd(A_MCAUSE,  32'hB,    0, "ecall_mcause");
    rd(A_MSTATUS, 32'h1880, 0, "ecall_mstatus");
    MD_mret_i = 1; MD_commit_valid_i = 1;
    expect_out(A_MSTATUS, 32'h1880, 0, 1, 32'h1000, "mret");
    tick(); clear_md();
    rd(A_MSTATUS, 32'h1888, 0, "mret_mstatus");

    // ecall and mret together: ecall wins
    MD_ecall_i = 1; MD_mret_i = 1; MD_pc_i = 32'h3000; MD_commit_valid_i = 1;
    expect_out(A_MCAUSE, 32'hB, 0, 1, 32'h80000100, "ecall_mret");
    tick(); clear_md();
    rd(A_MEPC,    32'h3000, 0, "both_mepc");
    rd(A_MSTATUS, 32'h1880, 0, "both_mstatus");
    MD_mret_i = 1; MD_commit_valid_i = 1;
    expect_out(A_MEPC, 32'h3000, 0, 1, 32'h3000, "mret2");
    tick(); clear_md();
    rd(A_MSTATUS, 32'h1888, 0, "mret2_mstatus");

    // Timer interrupt over a committing mscratch write
    timer_irq_i = 1;
    rd(A_MIP, 32'h80, 0, "mip_pending");
    MD_need_CSR_i = 1; MD_csr_op_i = 2'd0; MD_csr_addr_i = A_MSCRATCH;
    MD_csr_src_i = 32'hDEAD; MD_pc_i = 32'h2004; MD_commit_valid_i = 1;
    expect_out(A_MSCRATCH, 32'hFC, 0, 1, 32'h80000100, "irq");
    tick(); clear_md();
    timer_irq_i = 0;
    rd(A_MCAUSE,   32'h80000007, 0, "irq_mcause");
    rd(A_MEPC,     32'h2004,     0, "irq_mepc");
    rd(A_MSCRATCH, 32'hFC,       0, "irq_wr_suppressed");
    rd(A_MSTATUS,  32'h1880,     0, "irq_mstatus");

    // Counter halves and carry
    csr_wr(2'd0, A_MCYCLE, 32'h100);
    csr_wr(2'd0, A_MCYCLEH, 32'h1);
    rd(A_MCYCLE,  CNT_ON ? 32'h100 : 32'h0, 0, "cyc_lo_hold");
    rd(A_MCYCLEH, CNT_ON ? 32'h1 : 32'h0,   0, "cyc_hi_wr");
    csr_wr(2'd0, A_MCYCLE, 32'hFFFFFFFF);
    rd(A_MCYCLE,  CNT_ON ? 32'hFFFFFFFF : 32'h0, 0, "cyc_lo_max");
    rd(A_MCYCLEH, CNT_ON ? 32'h2 : 32'h0,        0, "cyc_carry");

    // Async reset mid-test with an ecall pending: no redirect, state cleared
    rst = 1; MD_ecall_i = 1; MD_commit_valid_i = 1; MD_pc_i = 32'h4000;
    rd(A_MTVEC,    32'h0,    0, "arst_mtvec");
    rd(A_MSCRATCH, 32'h0,    0, "arst_mscratch");
    rd(A_MEPC,     32'h0,    0, "arst_mepc");
    rd(A_MCAUSE,   32'hB,    0, "arst_mcause");
    rd(A_MSTATUS,  32'h1800, 0, "arst_mstatus");
    rd(A_MIE,      32'h0,    0, "arst_mie");
    rd(A_MCYCLE,   32'h0,    0, "arst_mcycle");
    clear_md();
    rst = 0;
    tick();
    tick();

    checks++;
    if (exp_d_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d entries unconsumed, want 0", exp_d_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
